// File: rtl/timer_cmp_if.sv
// Word-wide peripheral bus bundle for timer_cmp: register select, write strobe/data, read data
// and the interrupt level back to the host.
interface timer_cmp_if;
  logic [2:0]  addr;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        irq;

  modport master (
    output addr,
    output WD,
    output WE,
    input  RD,
    input  irq
  );

  modport slave (
    input  addr,
    input  WD,
    input  WE,
    output RD,
    output irq
  );
endinterface

// File: rtl/timer_cmp.sv
// Register-addressed prescaled timer with compare match, one-shot mode and level interrupt.
// Define TIMER_CAPTURE_EN to add the synchronised cap_in capture input and the CAP/CAPF state.
module timer_cmp #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [31:0] PRESC_RESET = 32'd49_999
) (
  input logic       clk,
  input logic       rst_n,
`ifdef TIMER_CAPTURE_EN
  input logic       cap_in,
`endif
  timer_cmp_if.slave bus
);

  logic             en_q, en_d;
  logic             oneshot_q, oneshot_d;
  logic             irq_en_q, irq_en_d;
  logic [31:0]      presc_q, presc_d;
  logic [31:0]      pc_q, pc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic             match_q, match_d;
  logic             capf_q;
  logic [WIDTH-1:0] cap_q;

  logic wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
  logic tick;

  assign wr_ctrl   = bus.WE && (bus.addr == 3'd0);
  assign wr_presc  = bus.WE && (bus.addr == 3'd1);
  assign wr_count  = bus.WE && (bus.addr == 3'd2);
  assign wr_cmp    = bus.WE && (bus.addr == 3'd3);
  assign wr_status = bus.WE && (bus.addr == 3'd4);

  assign tick = en_q && (pc_q == presc_q);

  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    presc_d   = presc_q;
    pc_d      = pc_q;
    count_d   = count_q;
    cmp_d     = cmp_q;
    match_d   = match_q;

    if (en_q) begin
      pc_d = tick ? 32'd0 : pc_q + 32'd1;
    end
    if (wr_count || wr_presc) begin
      pc_d = 32'd0;
    end

    if (wr_ctrl) begin
      en_d      = bus.WD[0];
      oneshot_d = bus.WD[1];
      irq_en_d  = bus.WD[2];
    end
    if (wr_presc) begin
      presc_d = bus.WD;
    end
    if (wr_cmp) begin
      cmp_d = bus.WD[WIDTH-1:0];
    end
    if (wr_status && bus.WD[0]) begin
      match_d = 1'b0;
    end

    // A COUNT write suppresses both the increment and the match check for that cycle.
    if (wr_count) begin
      count_d = bus.WD[WIDTH-1:0];
    end else if (tick) begin
      if (count_q == cmp_q) begin
        count_d = '0;
        match_d = 1'b1;
        if (oneshot_q) begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      oneshot_q <= 1'b0;
      irq_en_q  <= 1'b0;
      presc_q   <= PRESC_RESET;
      pc_q      <= 32'd0;
      count_q   <= '0;
      cmp_q     <= '1;
      match_q   <= 1'b0;
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      irq_en_q  <= irq_en_d;
      presc_q   <= presc_d;
      pc_q      <= pc_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      match_q   <= match_d;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic             sync1_q, sync2_q, sync3_q;
  logic             cap_rise;
  logic             capf_d;
  logic [WIDTH-1:0] cap_d;

  assign cap_rise = sync2_q && !sync3_q;

  always_comb begin
    capf_d = capf_q;
    cap_d  = cap_q;
    if (wr_status && bus.WD[1]) begin
      capf_d = 1'b0;
    end
    // Set beats a same-cycle clear; CAP sees COUNT before this edge's update.
    if (cap_rise) begin
      capf_d = 1'b1;
      cap_d  = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      capf_q  <= 1'b0;
      cap_q   <= '0;
    end else begin
      sync1_q <= cap_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      capf_q  <= capf_d;
      cap_q   <= cap_d;
    end
  end
`else
  assign capf_q = 1'b0;
  assign cap_q  = '0;
`endif

  logic [31:0] rd_data;

  always_comb begin
    rd_data = 32'd0;
    if (rst_n) begin
      case (bus.addr)
        3'd0:    rd_data = {29'd0, irq_en_q, oneshot_q, en_q};
        3'd1:    rd_data = presc_q;
        3'd2:    rd_data = 32'(count_q);
        3'd3:    rd_data = 32'(cmp_q);
        3'd4:    rd_data = {30'd0, capf_q, match_q};
        3'd5:    rd_data = 32'(cap_q);
        default: rd_data = 32'd0;
      endcase
    end
  end

  assign bus.RD  = rd_data;
  assign bus.irq = match_q && irq_en_q && rst_n;

endmodule
